// File: rtl/tone_detector.sv
`timescale 1ns/1ps
// tone_detector
// Listens to a buzzer square wave, measures the time between rising edges,
// classifies each period as one of four notes and declares a note once it has
// been seen CONF times in a row. A small FSM watches the declared notes and
// pulses melody_done when note0, note1, note2, note3 are each held for at
// least MIN_REP declared periods, in that order.
//
// Ports
//   clk         : single clock, everything on posedge
//   rst_n       : synchronous active-low reset
//   tone_in     : asynchronous square-wave input from the buzzer
//   note        : index of the most recently declared note
//   note_valid  : note is declared and stable
//   silence     : no rising edge for SIL_LIM cycles
//   melody_done : one-cycle pulse when the four-note melody is recognised
module tone_detector #(
  parameter int unsigned HP0     = 47000,
  parameter int unsigned HP1     = 42000,
  parameter int unsigned HP2     = 37500,
  parameter int unsigned HP3     = 33500,
  parameter int unsigned TOL     = 1000,
  parameter int unsigned CONF    = 4,
  parameter int unsigned MIN_REP = 64,
  parameter int unsigned SIL_LIM = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  output logic [1:0] note,
  output logic       note_valid,
  output logic       silence,
  output logic       melody_done
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  // Nominal full periods, 18 bits wide so P + TOL never overflows.
  localparam logic [3:0][17:0] NOM = {18'(2 * HP3), 18'(2 * HP2),
                                      18'(2 * HP1), 18'(2 * HP0)};
  localparam logic [17:0] TOL18   = 18'(TOL);
  localparam logic [16:0] SIL17   = 17'(SIL_LIM);
  localparam logic [7:0]  CONF8   = 8'(CONF);
  localparam logic [6:0]  MINREP7 = 7'(MIN_REP);

  logic        sync1_q, sync2_q, sync3_q, edge_q;
  logic [16:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [7:0]  run_q, run_d;
  logic [1:0]  runNote_q, runNote_d;
  logic [1:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        silence_q, silence_d;
  state_t      state_q, state_d, nextStage;
  logic [6:0]  dwell_q, dwell_d, dwellInc;
  logic        done_q, done_d;

  logic [17:0] period;
  logic [3:0]  matchVec;
  logic        matchAny;
  logic [1:0]  matchIdx, stageNote;
  logic        classify, silenceHit, declEdge, abortEvt;

  // Two-flop synchroniser, a third flop for edge detection, and a registered
  // edge strobe: a rising edge on tone_in is seen three cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // The counter value at an edge is the measured period; it saturates at
  // SIL_LIM so a stopped tone never wraps into a plausible period.
  assign cnt_d      = edge_q ? 17'd1 : ((cnt_q >= SIL17) ? cnt_q : cnt_q + 17'd1);
  assign silenceHit = !edge_q && (cnt_q >= SIL17);
  assign classify   = edge_q && armed_q;
  assign period     = {1'b0, cnt_q};

  // Window test for every note, then the lowest matching index wins.
  always_comb begin
    matchVec = '0;
    matchAny = 1'b0;
    matchIdx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      matchVec[k] = (period + TOL18 >= NOM[k]) && (period <= NOM[k] + TOL18);
    end
    for (int k = 3; k >= 0; k--) begin
      if (matchVec[k]) begin
        matchAny = 1'b1;
        matchIdx = 2'(k);
      end
    end
  end

  // Run-length confirmation of the note and the silence detector.
  always_comb begin
    armed_d   = armed_q;
    run_d     = run_q;
    runNote_d = runNote_q;
    note_d    = note_q;
    valid_d   = valid_q;
    silence_d = silence_q;
    if (edge_q) begin
      armed_d   = 1'b1;
      silence_d = 1'b0;
      if (armed_q) begin
        if (!matchAny) begin
          run_d = 8'd0;
        end else if (run_q != 8'd0 && runNote_q == matchIdx) begin
          run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end else begin
          run_d     = 8'd1;
          runNote_d = matchIdx;
        end
        valid_d = matchAny && (run_d >= CONF8);
        if (valid_d) begin
          note_d = matchIdx;
        end
      end
    end else if (silenceHit) begin
      silence_d = 1'b1;
      armed_d   = 1'b0;
      run_d     = 8'd0;
      valid_d   = 1'b0;
    end
  end

  // A declared edge is a classified period that leaves the note declared.
  // A note hand-over lowers note_valid for CONF-1 periods while the new note
  // is confirmed; that is how the melody advances, so only an unmatched
  // period or silence aborts the melody.
  assign declEdge = classify && valid_d;
  assign abortEvt = (classify && !matchAny) || silenceHit;
  assign dwellInc = (dwell_q == 7'h7F) ? dwell_q : dwell_q + 7'd1;

  always_comb begin
    stageNote = 2'd0;
    nextStage = IDLE;
    case (state_q)
      S0: begin
        stageNote = 2'd0;
        nextStage = S1;
      end
      S1: begin
        stageNote = 2'd1;
        nextStage = S2;
      end
      S2: begin
        stageNote = 2'd2;
        nextStage = S3;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    if (abortEvt) begin
      state_d = IDLE;
      dwell_d = 7'd0;
    end else if (declEdge) begin
      case (state_q)
        IDLE: begin
          if (note_d == 2'd0) begin
            state_d = S0;
            dwell_d = 7'd1;
          end
        end
        S0, S1, S2: begin
          if (note_d == stageNote) begin
            dwell_d = dwellInc;
          end else if (note_d == stageNote + 2'd1 && dwell_q >= MINREP7) begin
            state_d = nextStage;
            dwell_d = 7'd1;
          end else begin
            state_d = IDLE;
            dwell_d = 7'd0;
          end
        end
        S3: begin
          if (note_d == 2'd3) begin
            dwell_d = dwellInc;
            if (dwellInc >= MINREP7) begin
              done_d  = 1'b1;
              state_d = IDLE;
              dwell_d = 7'd0;
            end
          end else begin
            state_d = IDLE;
            dwell_d = 7'd0;
          end
        end
        default: begin
          state_d = IDLE;
          dwell_d = 7'd0;
        end
      endcase
    end
  end

  // State register for the counters, note confirmation and melody FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 17'd0;
      armed_q   <= 1'b0;
      run_q     <= 8'd0;
      runNote_q <= 2'd0;
      note_q    <= 2'd0;
      valid_q   <= 1'b0;
      silence_q <= 1'b0;
      state_q   <= IDLE;
      dwell_q   <= 7'd0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      run_q     <= run_d;
      runNote_q <= runNote_d;
      note_q    <= note_d;
      valid_q   <= valid_d;
      silence_q <= silence_d;
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      done_q    <= done_d;
    end
  end

  assign note        = note_q;
  assign note_valid  = valid_q;
  assign silence     = silence_q;
  assign melody_done = done_q;

endmodule

// File: tb/tb_tone_detector.sv
`timescale 1ns/1ps
// tb_tone_detector
// Drives whole square-wave periods into tone_detector (scaled-down note
// periods so a melody fits in a few thousand cycles) and compares the outputs
// three, four and five cycles after each rising edge against a behavioural
// model of the note/melody rules.
module tb_tone_detector;

  localparam int HP0     = 47;
  localparam int HP1     = 42;
  localparam int HP2     = 38;
  localparam int HP3     = 34;
  localparam int TOL     = 5;
  localparam int CONF    = 4;
  localparam int MIN_REP = 8;
  localparam int SIL_LIM = 300;

  logic       clk;
  logic       rst_n;
  logic       tone_in;
  logic [1:0] note;
  logic       note_valid;
  logic       silence;
  logic       melody_done;

  int vectors;
  int miscompares;
  int doneCount;
  int expDone;
  int sinceRise;

  // Behavioural model state.
  bit mArmed;
  bit mValid;
  bit mSilence;
  bit mPulse;
  int mNote;
  int mRunLen;
  int mRunNote;
  int mStage;
  int mDwell;

  tone_detector #(
    .HP0(HP0), .HP1(HP1), .HP2(HP2), .HP3(HP3), .TOL(TOL),
    .CONF(CONF), .MIN_REP(MIN_REP), .SIL_LIM(SIL_LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tone_in(tone_in),
    .note(note),
    .note_valid(note_valid),
    .silence(silence),
    .melody_done(melody_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int halfPeriod(int k);
    case (k)
      0: return HP0;
      1: return HP1;
      2: return HP2;
      default: return HP3;
    endcase
  endfunction

  // Lowest note whose nominal full period is within TOL of p, else -1.
  function automatic int classifyPeriod(int p);
    for (int k = 0; k < 4; k++) begin
      int d;
      d = p - 2 * halfPeriod(k);
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    sinceRise++;
    if (melody_done === 1'b1) doneCount++;
  endtask

  task automatic checkOutput(string tag, logic [1:0] eNote, logic eValid,
                             logic eSil, logic eDone);
    logic [4:0] observed;
    logic [4:0] expected;
    observed = {note, note_valid, silence, melody_done};
    expected = {eNote, eValid, eSil, eDone};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s @vec %0d: observed note=%0d valid=%0b silence=%0b done=%0b, expected note=%0d valid=%0b silence=%0b done=%0b",
             tag, vectors, observed[4:3], observed[2], observed[1], observed[0],
             expected[4:3], expected[2], expected[1], expected[0]);
    end
  endtask

  task automatic checkDoneCount(string tag);
    vectors++;
    assert (doneCount === expDone) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d melody_done pulses, expected %0d",
             tag, doneCount, expDone);
    end
  endtask

  task automatic modelSilence();
    mSilence = 1'b1;
    mValid   = 1'b0;
    mRunLen  = 0;
    mStage   = -1;
    mDwell   = 0;
    mArmed   = 1'b0;
  endtask

  task automatic melodyStep(int k);
    if (mStage < 0) begin
      if (k == 0) begin
        mStage = 0;
        mDwell = 1;
      end
    end else if (mStage < 3) begin
      if (k == mStage) begin
        mDwell = (mDwell < 127) ? mDwell + 1 : 127;
      end else if (k == mStage + 1 && mDwell >= MIN_REP) begin
        mStage = k;
        mDwell = 1;
      end else begin
        mStage = -1;
        mDwell = 0;
      end
    end else begin
      if (k == 3) begin
        mDwell++;
        if (mDwell >= MIN_REP) begin
          mPulse = 1'b1;
          expDone++;
          mStage = -1;
          mDwell = 0;
        end
      end else begin
        mStage = -1;
        mDwell = 0;
      end
    end
  endtask

  task automatic modelEdge(output logic [4:0] pre, output logic [4:0] post);
    int gap;
    int k;
    gap = sinceRise;
    sinceRise = 0;
    if (gap > SIL_LIM) modelSilence();
    pre = {2'(mNote), mValid, mSilence, 1'b0};
    mPulse = 1'b0;
    mSilence = 1'b0;
    if (!mArmed) begin
      mArmed = 1'b1;
    end else begin
      k = classifyPeriod(gap);
      if (k < 0) begin
        mRunLen = 0;
        mValid  = 1'b0;
        mStage  = -1;
        mDwell  = 0;
      end else begin
        if (mRunLen > 0 && mRunNote == k) begin
          mRunLen = (mRunLen < 255) ? mRunLen + 1 : 255;
        end else begin
          mRunLen  = 1;
          mRunNote = k;
        end
        mValid = (mRunLen >= CONF);
        if (mValid) begin
          mNote = k;
          melodyStep(k);
        end
      end
    end
    post = {2'(mNote), mValid, mSilence, mPulse};
  endtask

  // One full period: rising edge now, high for highLen cycles, low for the rest.
  task automatic applyStimulus(int period, int highLen);
    logic [4:0] pre;
    logic [4:0] post;
    modelEdge(pre, post);
    tone_in = 1'b1;
    for (int i = 1; i <= period; i++) begin
      tick();
      if (i == highLen) tone_in = 1'b0;
      if (i == 3) checkOutput("pre-edge", pre[4:3], pre[2], pre[1], pre[0]);
      if (i == 4) checkOutput("post-edge", post[4:3], post[2], post[1], post[0]);
      if (i == 5) checkOutput("settled", post[4:3], post[2], post[1], 1'b0);
      if (i == SIL_LIM + 3) checkOutput("before-silence", post[4:3], post[2], 1'b0, 1'b0);
      if (i == SIL_LIM + 4) begin
        modelSilence();
        checkOutput("silence", post[4:3], 1'b0, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic playTone(int k, int periods);
    for (int n = 0; n < periods; n++) begin
      applyStimulus(2 * halfPeriod(k), halfPeriod(k));
    end
  endtask

  task automatic applyReset(int cycles);
    tone_in = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    checkOutput("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    mArmed = 1'b0;
    mValid = 1'b0;
    mSilence = 1'b0;
    mPulse = 1'b0;
    mNote = 0;
    mRunLen = 0;
    mRunNote = 0;
    mStage = -1;
    mDwell = 0;
    sinceRise = 0;
  endtask

  initial begin
    int boundary[12];
    int k;
    int reps;
    int p;
    vectors = 0;
    miscompares = 0;
    doneCount = 0;
    expDone = 0;
    sinceRise = 0;
    tone_in = 1'b0;
    rst_n = 1'b0;

    applyReset(3);

    // Steady note 0: declared after the fifth rising edge.
    playTone(0, 6);

    // Window edges of note 0 (89 also sits on note 1's window), then a miss.
    applyStimulus(99, 49);
    applyStimulus(89, 44);
    applyStimulus(100, 50);

    // Window boundaries and the note2/note3 and note1/note2 overlaps.
    boundary = '{63, 62, 73, 70, 71, 81, 82, 79, 84, 68, 68, 68};
    foreach (boundary[i]) applyStimulus(boundary[i], boundary[i] / 2);

    // Single-cycle high and low pulses count as ordinary edges.
    for (int n = 0; n < 3; n++) applyStimulus(84, 1);
    for (int n = 0; n < 3; n++) applyStimulus(84, 83);

    // Long gap: counter saturates, silence exactly SIL_LIM cycles after the edge.
    applyStimulus(SIL_LIM + 50, 20);

    // Full melody, back to back, plus a trailing edge.
    playTone(0, 12);
    playTone(1, 12);
    playTone(2, 12);
    playTone(3, 12);
    applyStimulus(68, 34);
    checkDoneCount("melody");

    // Skipping note 1 aborts the melody; then the tone stops.
    playTone(0, 12);
    playTone(2, 12);
    applyStimulus(SIL_LIM + 40, 38);
    checkDoneCount("skip-note");

    // Reset in S2 aborts; note 3 afterwards must not complete anything.
    playTone(0, 12);
    playTone(1, 12);
    playTone(2, 10);
    applyReset(1);
    playTone(3, 12);
    checkDoneCount("reset-abort");

    // Randomised runs of near-nominal and arbitrary periods.
    for (int g = 0; g < 40; g++) begin
      k = $urandom_range(0, 4);
      reps = $urandom_range(1, 9);
      for (int r = 0; r < reps; r++) begin
        if (k == 4) p = $urandom_range(40, 110);
        else p = 2 * halfPeriod(k) + int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
        applyStimulus(p, $urandom_range(1, p - 1));
      end
    end
    checkDoneCount("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
